// File: rtl/mirror_pkg.sv
// Shared types and default sizes for the CCD horizontal-mirror line sequencer.
package mirror_pkg;

    localparam int DEF_LINE_W = 320;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_FILL    = 2'd1,
        W_DISCARD = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/mirror_line_ctrl_if.sv
// Capture-side and RAM-side signals of the mirror line sequencer.
interface mirror_line_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              iCCD_DVAL;
    logic              iMIRROR_EN;
    logic [ADDR_W-1:0] oWR_ADDR;
    logic              oWR_BANK;
    logic              oWREN;
    logic [ADDR_W-1:0] oRD_ADDR;
    logic              oRD_BANK;
    logic              oRD_EN;
    logic              oCCD_DVAL;
    logic              oLINE_DONE;
    logic              oOVERRUN;

    modport master (
        output iCCD_DVAL, iMIRROR_EN,
        input  oWR_ADDR, oWR_BANK, oWREN, oRD_ADDR, oRD_BANK,
               oRD_EN, oCCD_DVAL, oLINE_DONE, oOVERRUN
    );

    modport slave (
        input  iCCD_DVAL, iMIRROR_EN,
        output oWR_ADDR, oWR_BANK, oWREN, oRD_ADDR, oRD_BANK,
               oRD_EN, oCCD_DVAL, oLINE_DONE, oOVERRUN
    );
endinterface

// File: rtl/mirror_rd_seq.sv
// Read sequencer: issues len read addresses, counting down (mirror) or up (straight).
module mirror_rd_seq
    import mirror_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              mirror,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              last
);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    rd_state_t       state_reg, state_next;
    logic [ADDR_W:0] rcnt_reg, rcnt_next;
    logic [ADDR_W:0] len_reg, len_next;
    logic            mirror_reg, mirror_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= R_IDLE;
            rcnt_reg   <= '0;
            len_reg    <= '0;
            mirror_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rcnt_reg   <= rcnt_next;
            len_reg    <= len_next;
            mirror_reg <= mirror_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rcnt_next   = rcnt_reg;
        len_next    = len_reg;
        mirror_next = mirror_reg;
        rd_en       = 1'b0;
        last        = 1'b0;
        case (state_reg)
            R_READ: begin
                rd_en = 1'b1;
                last  = mirror_reg ? (rcnt_reg == '0) : (rcnt_reg == len_reg - ONE);
                if (last) begin
                    state_next = R_IDLE;
                    rcnt_next  = '0;
                end else begin
                    rcnt_next = mirror_reg ? rcnt_reg - ONE : rcnt_reg + ONE;
                end
            end
            default: ;
        endcase
        // A new line may start on the very cycle the previous one issues its last address.
        if (start && (state_reg == R_IDLE || last)) begin
            state_next  = R_READ;
            len_next    = len;
            mirror_next = mirror;
            rcnt_next   = mirror ? len - ONE : '0;
        end
    end

    assign busy    = (state_reg == R_READ);
    assign rd_addr = rcnt_reg[ADDR_W-1:0];

endmodule

// File: rtl/mirror_line_ctrl.sv
// Ping-pong line-buffer sequencer: writes a line in one bank while reading the previous one out of the other.
module mirror_line_ctrl
    import mirror_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic               iCCD_PIXCLK,
    input  logic               iRST,
    mirror_line_ctrl_if.slave  bus
);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LINE_LEN  = (ADDR_W+1)'(LINE_W);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(LINE_W - 1);

    wr_state_t       wr_state_reg, wr_state_next;
    logic [ADDR_W:0] wcnt_reg, wcnt_next;
    logic            wr_bank_reg, rd_bank_reg;
    logic            line_done_reg, overrun_reg, ccd_dval_reg;

    logic            wr_en;
    logic [ADDR_W:0] beat_addr;
    logic            complete;
    logic [ADDR_W:0] comp_len;
    logic            rd_start, rd_free;
    logic            rd_en, rd_busy, rd_last;
    logic [ADDR_W-1:0] rd_addr;

    always_comb begin
        wr_state_next = wr_state_reg;
        wcnt_next     = wcnt_reg;
        wr_en         = 1'b0;
        beat_addr     = '0;
        complete      = 1'b0;
        comp_len      = '0;
        case (wr_state_reg)
            W_IDLE: begin
                if (bus.iCCD_DVAL) begin
                    wr_en = 1'b1;
                    if (LAST_ADDR == '0) begin
                        complete      = 1'b1;
                        comp_len      = LINE_LEN;
                        wr_state_next = W_DISCARD;
                    end else begin
                        wr_state_next = W_FILL;
                        wcnt_next     = ONE;
                    end
                end
            end
            W_FILL: begin
                beat_addr = wcnt_reg;
                if (bus.iCCD_DVAL) begin
                    wr_en = 1'b1;
                    if (wcnt_reg == LAST_ADDR) begin
                        // Full line: anything still arriving belongs to an over-long line.
                        complete      = 1'b1;
                        comp_len      = LINE_LEN;
                        wr_state_next = W_DISCARD;
                        wcnt_next     = '0;
                    end else begin
                        wcnt_next = wcnt_reg + ONE;
                    end
                end else begin
                    complete      = 1'b1;
                    comp_len      = wcnt_reg;
                    wr_state_next = W_IDLE;
                    wcnt_next     = '0;
                end
            end
            W_DISCARD: begin
                if (!bus.iCCD_DVAL) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign rd_free  = !rd_busy || rd_last;
    assign rd_start = complete && rd_free;

    always_ff @(posedge iCCD_PIXCLK or posedge iRST) begin
        if (iRST) begin
            wr_state_reg  <= W_IDLE;
            wcnt_reg      <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b1;
            line_done_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            ccd_dval_reg  <= 1'b0;
        end else begin
            wr_state_reg  <= wr_state_next;
            wcnt_reg      <= wcnt_next;
            line_done_reg <= rd_start;
            overrun_reg   <= complete && !rd_free;
            ccd_dval_reg  <= rd_en;
            if (rd_start) begin
                wr_bank_reg <= ~wr_bank_reg;
                rd_bank_reg <= wr_bank_reg;
            end
        end
    end

    mirror_rd_seq #(
        .ADDR_W (ADDR_W)
    ) u_rd_seq (
        .clk     (iCCD_PIXCLK),
        .rst     (iRST),
        .start   (rd_start),
        .len     (comp_len),
        .mirror  (bus.iMIRROR_EN),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .busy    (rd_busy),
        .last    (rd_last)
    );

    // Write enable is combinational from DVAL, so hold it low while reset is asserted.
    assign bus.oWREN      = wr_en && !iRST;
    assign bus.oWR_ADDR   = beat_addr[ADDR_W-1:0];
    assign bus.oWR_BANK   = wr_bank_reg;
    assign bus.oRD_ADDR   = rd_addr;
    assign bus.oRD_BANK   = rd_bank_reg;
    assign bus.oRD_EN     = rd_en;
    assign bus.oCCD_DVAL  = ccd_dval_reg;
    assign bus.oLINE_DONE = line_done_reg;
    assign bus.oOVERRUN   = overrun_reg;

endmodule

// File: tb/tb_mirror_line_ctrl.sv
// Scoreboard bench for mirror_line_ctrl with a behavioural two-bank line RAM.
module tb_mirror_line_ctrl;
    import mirror_pkg::*;

    localparam int LW = 8;
    localparam int AW = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix = '0;

    always #5 clk = ~clk;

    mirror_line_ctrl_if #(.ADDR_W(AW)) bus ();

    mirror_line_ctrl #(
        .LINE_W (LW),
        .ADDR_W (AW)
    ) dut (
        .iCCD_PIXCLK (clk),
        .iRST        (rst),
        .bus         (bus.slave)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         ld_cnt = 0;
    int         ov_cnt = 0;
    int         rd_q[$];
    logic [7:0] pix_q[$];

    logic [7:0] mem0 [0:(1<<AW)-1];
    logic [7:0] mem1 [0:(1<<AW)-1];
    logic [7:0] q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two RAM banks with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.oWREN) begin
            if (bus.oWR_BANK) mem1[bus.oWR_ADDR] <= pix;
            else              mem0[bus.oWR_ADDR] <= pix;
        end
        if (bus.oRD_EN) q <= bus.oRD_BANK ? mem1[bus.oRD_ADDR] : mem0[bus.oRD_ADDR];
    end

    // Monitor: pops the scoreboard whenever a read address or output pixel appears.
    always @(negedge clk) begin
        if (rst) begin
            ld_cnt = 0;
            ov_cnt = 0;
        end else begin
            if (bus.oLINE_DONE) ld_cnt++;
            if (bus.oOVERRUN)   ov_cnt++;
            if (bus.oRD_EN) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'(bus.oRD_EN), 32'd0);
                else begin
                    int e;
                    e = rd_q.pop_front();
                    chk("rd_bank_addr", {15'd0, bus.oRD_BANK, 6'd0, bus.oRD_ADDR}, 32'(e));
                    $display("rd  bank=%0d addr=%0d", bus.oRD_BANK, bus.oRD_ADDR);
                end
            end
            if (bus.oCCD_DVAL) begin
                if (pix_q.size() == 0) chk("pix_unexpected", 32'(bus.oCCD_DVAL), 32'd0);
                else begin
                    logic [7:0] ep;
                    ep = pix_q.pop_front();
                    chk("pixel", 32'(q), 32'(ep));
                    $display("out pixel=%02h", q);
                end
            end
        end
    end

    task automatic push_line(input bit bank, input int len, input bit mir, input logic [7:0] tag);
        for (int i = 0; i < len; i++) begin
            int a;
            a = mir ? (len - 1 - i) : i;
            rd_q.push_back((int'(bank) << 16) | a);
            pix_q.push_back(8'(tag + 8'(a)));
        end
    endtask

    task automatic beat(input bit dval, input logic [7:0] p, input bit exp_wren, input int exp_addr);
        @(posedge clk);
        #1;
        bus.iCCD_DVAL = dval;
        pix = p;
        #1;
        chk("wren", 32'(bus.oWREN), 32'(exp_wren));
        if (exp_wren) chk("wr_addr", 32'(bus.oWR_ADDR), 32'(exp_addr));
    endtask

    task automatic send_line(input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++) beat(1'b1, 8'(tag + 8'(i)), i < LW, i);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (rd_q.size() != 0 || pix_q.size() != 0); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        chk("drain_rd_q", 32'(rd_q.size()), 32'd0);
        chk("drain_pix_q", 32'(pix_q.size()), 32'd0);
        rd_q.delete();
        pix_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.iCCD_DVAL = 1'b0;
        bus.iMIRROR_EN = 1'b0;
        #2;
        chk("rst_wr_bank", 32'(bus.oWR_BANK), 32'd0);
        chk("rst_rd_bank", 32'(bus.oRD_BANK), 32'd1);
        chk("rst_strobes", {27'd0, bus.oWREN, bus.oRD_EN, bus.oCCD_DVAL, bus.oLINE_DONE, bus.oOVERRUN}, 32'd0);
        chk("rst_addrs", {6'd0, bus.oWR_ADDR, 6'd0, bus.oRD_ADDR}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.iCCD_DVAL = 1'b0;
        bus.iMIRROR_EN = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Full mirrored line
        bus.iMIRROR_EN = 1'b1;
        push_line(1'b0, 8, 1'b1, 8'h10);
        send_line(8, 8'h10);
        beat(1'b0, 8'h00, 1'b0, 0);
        chk("t1_line_done", 32'(bus.oLINE_DONE), 32'd1);
        chk("t1_first_rd", {23'd0, bus.oRD_EN, bus.oRD_BANK, bus.oWR_BANK, bus.oCCD_DVAL, 3'd0, bus.oRD_ADDR[1:0]},
            {23'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd3});
        chk("t1_rd_addr", 32'(bus.oRD_ADDR), 32'd7);
        beat(1'b0, 8'h00, 1'b0, 0);
        chk("t1_dval_t2", 32'(bus.oCCD_DVAL), 32'd1);
        chk("t1_done_pulse", 32'(bus.oLINE_DONE), 32'd0);
        drain();
        chk("t1_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("t1_ov_cnt", 32'(ov_cnt), 32'd0);

        // Straight short line
        do_reset();
        bus.iMIRROR_EN = 1'b0;
        push_line(1'b0, 5, 1'b0, 8'h20);
        send_line(5, 8'h20);
        beat(1'b0, 8'h00, 1'b0, 0);
        beat(1'b0, 8'h00, 1'b0, 0);
        chk("t2_line_done", 32'(bus.oLINE_DONE), 32'd1);
        chk("t2_wr_bank", 32'(bus.oWR_BANK), 32'd1);
        chk("t2_rd_addr", 32'(bus.oRD_ADDR), 32'd0);
        drain();
        chk("t2_ld_cnt", 32'(ld_cnt), 32'd1);

        // Over-long line
        do_reset();
        bus.iMIRROR_EN = 1'b1;
        push_line(1'b0, 8, 1'b1, 8'h30);
        for (int i = 0; i < 11; i++) begin
            beat(1'b1, 8'(8'h30 + 8'(i)), i < LW, i);
            if (i >= LW) chk("t3_discard", 32'(dut.wr_state_reg), 32'(W_DISCARD));
        end
        beat(1'b0, 8'h00, 1'b0, 0);
        drain();
        chk("t3_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("t3_ov_cnt", 32'(ov_cnt), 32'd0);

        // Overrun: short line completes while the previous readout is active
        do_reset();
        bus.iMIRROR_EN = 1'b0;
        push_line(1'b0, 8, 1'b0, 8'h40);
        send_line(8, 8'h40);
        beat(1'b0, 8'h00, 1'b0, 0);
        beat(1'b1, 8'h50, 1'b1, 0);
        beat(1'b1, 8'h51, 1'b1, 1);
        chk("t4_wr_bank_b", 32'(bus.oWR_BANK), 32'd1);
        beat(1'b0, 8'h00, 1'b0, 0);
        beat(1'b0, 8'h00, 1'b0, 0);
        chk("t4_overrun", 32'(bus.oOVERRUN), 32'd1);
        chk("t4_no_done", 32'(bus.oLINE_DONE), 32'd0);
        chk("t4_bank_kept", 32'(bus.oWR_BANK), 32'd1);
        drain();
        chk("t4_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("t4_ov_cnt", 32'(ov_cnt), 32'd1);

        // Boundary: completion on the cycle the last read address is issued
        do_reset();
        bus.iMIRROR_EN = 1'b1;
        push_line(1'b0, 8, 1'b1, 8'h60);
        push_line(1'b1, 6, 1'b0, 8'h70);
        send_line(8, 8'h60);
        beat(1'b0, 8'h00, 1'b0, 0);
        bus.iMIRROR_EN = 1'b0;
        send_line(6, 8'h70);
        beat(1'b0, 8'h00, 1'b0, 0);
        chk("t5_last_rd", {30'd0, bus.oRD_EN, bus.oRD_BANK}, 32'd2);
        chk("t5_last_addr", 32'(bus.oRD_ADDR), 32'd0);
        beat(1'b0, 8'h00, 1'b0, 0);
        chk("t5_line_done", 32'(bus.oLINE_DONE), 32'd1);
        chk("t5_no_overrun", 32'(bus.oOVERRUN), 32'd0);
        chk("t5_banks", {30'd0, bus.oWR_BANK, bus.oRD_BANK}, 32'd1);
        drain();
        chk("t5_ld_cnt", 32'(ld_cnt), 32'd2);
        chk("t5_ov_cnt", 32'(ov_cnt), 32'd0);

        // Reset mid-line, then a fresh line
        do_reset();
        bus.iMIRROR_EN = 1'b0;
        send_line(3, 8'h80);
        do_reset();
        repeat (3) beat(1'b0, 8'h00, 1'b0, 0);
        chk("t6_no_pulses", 32'(ld_cnt + ov_cnt), 32'd0);
        chk("t6_idle_rd", 32'(bus.oRD_EN), 32'd0);
        push_line(1'b0, 8, 1'b0, 8'h90);
        send_line(8, 8'h90);
        beat(1'b0, 8'h00, 1'b0, 0);
        drain();
        chk("t6_ld_cnt", 32'(ld_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
